// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: packet-locked round-robin arbiter from four VC buffers
// onto one output link, with a one-deep registered output stage.
module vc_output_arbiter (
  input  logic         clk,
  input  logic         arst,
  input  logic [135:0] vc_fdata_i,
  input  logic [3:0]   vc_valid_i,
  output logic [3:0]   vc_ready_o,
  output logic [33:0]  fdata_o,
  output logic [1:0]   vc_id_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         locked_o
);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t      r_state;
  logic [1:0]  r_lock_vc;
  logic [1:0]  r_rr_ptr;
  logic [33:0] r_fdata;
  logic [1:0]  r_vc_id;
  logic        r_valid;

  logic        w_load_en;
  logic [3:0]  w_head;
  logic [1:0]  w_grant;
  logic        w_found;
  logic [3:0]  w_ready;
  logic [1:0]  w_xvc;
  logic        w_xfer;
  logic [33:0] w_xflit;
  logic [1:0]  w_xtype;

  assign w_load_en = ~r_valid | ready_i;

  // A VC is eligible for a new grant only when it offers a head flit
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_head[n] = vc_valid_i[n] &
                  (vc_fdata_i[34*n+32 +: 2] == 2'b00);
    end
  end

  // Round-robin search starting just after the last granted VC
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_grant = 2'd0;
    idx     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = r_rr_ptr + 2'(i);
      if (!w_found && w_head[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  // One-hot ready: winner in IDLE, the locked VC otherwise
  always_comb begin
    w_ready = 4'b0000;
    if (!arst && w_load_en) begin
      case (r_state)
        S_IDLE: begin
          if (w_found) w_ready[w_grant] = 1'b1;
        end
        S_LOCKED: w_ready[r_lock_vc] = 1'b1;
        default: w_ready = 4'b0000;
      endcase
    end
  end

  assign w_xvc   = (r_state == S_LOCKED) ? r_lock_vc : w_grant;
  assign w_xfer  = |(vc_valid_i & w_ready);
  assign w_xflit = vc_fdata_i[34*w_xvc +: 34];
  assign w_xtype = w_xflit[33:32];

  // Output register: load on transfer, drop valid on drain, hold on stall
  always_ff @(posedge clk) begin
    if (arst) begin
      r_fdata <= 34'd0;
      r_vc_id <= 2'd0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_fdata <= w_xflit;
      r_vc_id <= w_xvc;
      r_valid <= 1'b1;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // Packet lock FSM; rr_ptr resets to 3 so VC0 is searched first
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state   <= S_IDLE;
      r_lock_vc <= 2'd0;
      r_rr_ptr  <= 2'd3;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_rr_ptr <= w_xvc;
            if (w_xtype != 2'b11) begin
              r_state   <= S_LOCKED;
              r_lock_vc <= w_xvc;
            end
          end
        end
        S_LOCKED: begin
          if (w_xfer && w_xtype == 2'b11)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vc_ready_o = w_ready;
  assign fdata_o    = r_fdata;
  assign vc_id_o    = r_vc_id;
  assign valid_o    = r_valid;
  assign locked_o   = (r_state == S_LOCKED);

endmodule
